w_channel_route_queue: RTL and testbench
========================================

Name: w_channel_route_queue

Overview:
Write-data (W) routing stage that sits directly downstream of the AW channel controller in the interconnect. Each completed AW grant pushes a {master, slave, awlen} entry into an in-order queue. The head entry steers the granted master's W beats to the target slave and counts them against awlen. The block pops the entry on the final beat and returns Queue_Is_Full to the AW controller so address acceptance stalls when the queue is full.

Parameters:
Masters_Num, 2, number of upstream masters (S00, S01)
Slaves_ID_Size, $clog2(Masters_Num), width of master ID field
Num_Of_Slaves, 2, number of downstream slaves (M00, M01)
Slave_Sel_Width, 1, width of slave index
Data_Width, 32, W data width
Queue_Depth, 4, route-queue entries (power of 2, ≥2)

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESET  in  1  asynchronous, active-high reset
AW_Access_Grant  in  1  one-cycle pulse per completed AW handshake; push strobe
AW_Granted_Master  in  Slaves_ID_Size  master ID of the grant
AW_Target_Slave  in  Slave_Sel_Width  decoded slave index of the grant
AW_Granted_Len  in  8  awlen of the grant (beats−1)
Queue_Is_Full  out  1  count==Queue_Depth, to AW controller
S00_AXI_wdata/wstrb/wlast/wvalid  in  Data_Width/Data_Width/8/1/1  master 0 W channel
S00_AXI_wready  out  1
S01_AXI_wdata/wstrb/wlast/wvalid  in  same as S00  master 1 W channel
S01_AXI_wready  out  1
M00_AXI_wdata/wstrb/wlast/wvalid  out  Data_Width/Data_Width/8/1/1  slave 0 W channel
M00_AXI_wready  in  1
M01_* / M01_AXI_wready  same as M00  slave 1 W channel
W_Len_Error  out  1  sticky: master wlast disagreed with awlen count
Queue_Overflow  out  1  sticky: grant pulse arrived while full

Behaviour:
- Reset (async assert, sync release): count=0, rd/wr pointers=0, beat_cnt=0, both error flags=0; all wvalid/wready outputs=0, Queue_Is_Full=0, wlast outputs=0, data outputs=0.
- Push: AW_Access_Grant && !Queue_Is_Full writes the entry at wr_ptr; wr_ptr increments modulo Queue_Depth.
- Grant while full: entry dropped, Queue_Overflow set. A pop in the same cycle does not admit it.
- Head valid: count>0. An entry pushed into an empty queue routes from the next cycle (1-cycle latency).
- Routing (combinational from registered head): M<head.slave>_wvalid = S<head.master>_wvalid & head_valid. Data/strb pass through from the selected master.
- Routing, ready and idle paths: S<head.master>_wready = M<head.slave>_wready & head_valid. All other wvalid/wready=0. Non-selected M data=0.
- Beat handshake: selected master's wvalid & target wready & head_valid.
- beat_cnt: 8-bit. Increments per handshake; clears to 0 on the last beat.
- Output wlast: asserted when beat_cnt==head.len. It is generated from the count, not forwarded from the master.
- Length check: on any handshake, if master wlast != (beat_cnt==head.len), W_Len_Error is set (sticky until reset). Routing still follows the count.
- Pop: on the last-beat handshake, rd_ptr increments. The next head takes effect the following cycle, so back-to-back bursts have zero bubble.
- Count: push only → +1; pop only → −1; push and pop in same cycle → unchanged.
- awlen=0: single beat, wlast on first beat. awlen=255: 256 beats, beat_cnt reaches 255 without wrap error.
- Master asserts wvalid with no matching head: wready held 0, no beat consumed.
- Reset mid-burst: queue and counters cleared immediately. Remaining beats are ignored until new grants.

Test Plan:
- Grant {M0→S0, len=3}, S00 sends 4 beats 0xA0..0xA3 with wlast on beat 4, M00_wready=1 → M00 sees 4 beats in order, wlast on 4th only, queue empty after, W_Len_Error=0.
- Grants {M0→S1, len=0} then {M1→S0, len=1}, both masters valid → M01 gets 1 beat from S00, then the next cycle M00 gets 2 beats from S01, with no idle cycle between.
- Four grants with no W traffic → Queue_Is_Full=1. Fifth grant → Queue_Overflow=1, count stays 4. Completing one burst → Queue_Is_Full=0.
- Grant and last-beat pop in the same cycle at count=2 → count remains 2, FIFO order preserved.
- Grant {M1→S0, len=2}, S01 asserts wlast on beat 2 → W_Len_Error=1, M00_wlast on beat 3, entry popped after beat 3.
- Backpressure: M00_wready toggles 1,0,0,1,… during len=3 burst → exactly 4 handshakes, data is never lost or duplicated. ARESET pulse mid-burst → all outputs 0 and count 0 within the same cycle.

Source files
------------

// File: rtl/w_channel_route_queue.sv
// W-channel routing stage: an in-order queue of AW grants steers each granted master's
// W beats to its target slave and counts them against awlen.
module w_channel_route_queue #(
    parameter int unsigned Masters_Num     = 2,
    parameter int unsigned Slaves_ID_Size  = $clog2(Masters_Num),
    parameter int unsigned Num_Of_Slaves   = 2,
    parameter int unsigned Slave_Sel_Width = 1,
    parameter int unsigned Data_Width      = 32,
    parameter int unsigned Queue_Depth     = 4
) (
    input  logic                       ACLK,
    input  logic                       ARESET,

    input  logic                       AW_Access_Grant,
    input  logic [Slaves_ID_Size-1:0]  AW_Granted_Master,
    input  logic [Slave_Sel_Width-1:0] AW_Target_Slave,
    input  logic [7:0]                 AW_Granted_Len,
    output logic                       Queue_Is_Full,

    input  logic [Data_Width-1:0]      S00_AXI_wdata,
    input  logic [Data_Width/8-1:0]    S00_AXI_wstrb,
    input  logic                       S00_AXI_wlast,
    input  logic                       S00_AXI_wvalid,
    output logic                       S00_AXI_wready,

    input  logic [Data_Width-1:0]      S01_AXI_wdata,
    input  logic [Data_Width/8-1:0]    S01_AXI_wstrb,
    input  logic                       S01_AXI_wlast,
    input  logic                       S01_AXI_wvalid,
    output logic                       S01_AXI_wready,

    output logic [Data_Width-1:0]      M00_AXI_wdata,
    output logic [Data_Width/8-1:0]    M00_AXI_wstrb,
    output logic                       M00_AXI_wlast,
    output logic                       M00_AXI_wvalid,
    input  logic                       M00_AXI_wready,

    output logic [Data_Width-1:0]      M01_AXI_wdata,
    output logic [Data_Width/8-1:0]    M01_AXI_wstrb,
    output logic                       M01_AXI_wlast,
    output logic                       M01_AXI_wvalid,
    input  logic                       M01_AXI_wready,

    output logic                       W_Len_Error,
    output logic                       Queue_Overflow
);

    localparam int unsigned Ptr_Width  = (Queue_Depth > 1) ? $clog2(Queue_Depth) : 1;
    localparam int unsigned Cnt_Width  = Ptr_Width + 1;
    localparam int unsigned Strb_Width = Data_Width / 8;
    localparam logic [Cnt_Width-1:0] Full_Count = Cnt_Width'(Queue_Depth);

    // Route queue storage; contents are qualified by count so they need no reset.
    logic [Slaves_ID_Size-1:0]  q_master [Queue_Depth];
    logic [Slave_Sel_Width-1:0] q_slave  [Queue_Depth];
    logic [7:0]                 q_len    [Queue_Depth];

    logic [Ptr_Width-1:0] wr_ptr;
    logic [Ptr_Width-1:0] rd_ptr;
    logic [Cnt_Width-1:0] count;
    logic [7:0]           beat_cnt;
    logic                 len_error;
    logic                 overflow;

    logic                       head_valid;
    logic [Slaves_ID_Size-1:0]  head_master;
    logic [Slave_Sel_Width-1:0] head_slave;
    logic [7:0]                 head_len;
    logic                       push;
    logic                       pop;
    logic                       handshake;
    logic                       last_beat;

    logic [Data_Width-1:0] s_wdata  [Masters_Num];
    logic [Strb_Width-1:0] s_wstrb  [Masters_Num];
    logic                  s_wlast  [Masters_Num];
    logic                  s_wvalid [Masters_Num];
    logic                  s_wready [Masters_Num];

    logic [Data_Width-1:0] m_wdata  [Num_Of_Slaves];
    logic [Strb_Width-1:0] m_wstrb  [Num_Of_Slaves];
    logic                  m_wlast  [Num_Of_Slaves];
    logic                  m_wvalid [Num_Of_Slaves];
    logic                  m_wready [Num_Of_Slaves];

    logic [Data_Width-1:0] sel_wdata;
    logic [Strb_Width-1:0] sel_wstrb;
    logic                  sel_wlast;
    logic                  sel_wvalid;
    logic                  tgt_wready;

    assign s_wdata[0]  = S00_AXI_wdata;
    assign s_wstrb[0]  = S00_AXI_wstrb;
    assign s_wlast[0]  = S00_AXI_wlast;
    assign s_wvalid[0] = S00_AXI_wvalid;
    assign s_wdata[1]  = S01_AXI_wdata;
    assign s_wstrb[1]  = S01_AXI_wstrb;
    assign s_wlast[1]  = S01_AXI_wlast;
    assign s_wvalid[1] = S01_AXI_wvalid;
    assign m_wready[0] = M00_AXI_wready;
    assign m_wready[1] = M01_AXI_wready;

    assign head_valid  = (count != '0);
    assign head_master = q_master[rd_ptr];
    assign head_slave  = q_slave[rd_ptr];
    assign head_len    = q_len[rd_ptr];

    assign sel_wdata  = s_wdata[head_master];
    assign sel_wstrb  = s_wstrb[head_master];
    assign sel_wlast  = s_wlast[head_master];
    assign sel_wvalid = s_wvalid[head_master];
    assign tgt_wready = m_wready[head_slave];

    assign Queue_Is_Full = (count == Full_Count);
    assign last_beat     = (beat_cnt == head_len);
    assign handshake     = sel_wvalid & tgt_wready & head_valid;
    assign pop           = handshake & last_beat;
    // Fullness is judged before this cycle's pop, so a pop never admits a grant while full.
    assign push          = AW_Access_Grant & ~Queue_Is_Full;

    always_ff @(posedge ACLK) begin
        if (push) begin
            q_master[wr_ptr] <= AW_Granted_Master;
            q_slave[wr_ptr]  <= AW_Target_Slave;
            q_len[wr_ptr]    <= AW_Granted_Len;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            beat_cnt  <= '0;
            len_error <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (handshake) begin
                beat_cnt <= last_beat ? 8'd0 : beat_cnt + 8'd1;
            end
            // Beat routing follows the count; a mismatching master wlast is only flagged.
            if (handshake && (sel_wlast != last_beat)) begin
                len_error <= 1'b1;
            end
            if (AW_Access_Grant && Queue_Is_Full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        m_wdata  = '{default: '0};
        m_wstrb  = '{default: '0};
        m_wlast  = '{default: 1'b0};
        m_wvalid = '{default: 1'b0};
        s_wready = '{default: 1'b0};
        if (head_valid) begin
            m_wdata[head_slave]   = sel_wdata;
            m_wstrb[head_slave]   = sel_wstrb;
            m_wlast[head_slave]   = last_beat;
            m_wvalid[head_slave]  = sel_wvalid;
            s_wready[head_master] = tgt_wready;
        end
    end

    assign S00_AXI_wready = s_wready[0];
    assign S01_AXI_wready = s_wready[1];

    assign M00_AXI_wdata  = m_wdata[0];
    assign M00_AXI_wstrb  = m_wstrb[0];
    assign M00_AXI_wlast  = m_wlast[0];
    assign M00_AXI_wvalid = m_wvalid[0];
    assign M01_AXI_wdata  = m_wdata[1];
    assign M01_AXI_wstrb  = m_wstrb[1];
    assign M01_AXI_wlast  = m_wlast[1];
    assign M01_AXI_wvalid = m_wvalid[1];

    assign W_Len_Error    = len_error;
    assign Queue_Overflow = overflow;

endmodule

// File: tb/tb_w_channel_route_queue.sv
// Bench for w_channel_route_queue: directed scenarios plus random traffic, all checked
// every cycle against a queue-based model of the routing rules.
module tb_w_channel_route_queue;

    logic        ACLK;
    logic        ARESET;
    logic        AW_Access_Grant;
    logic [0:0]  AW_Granted_Master;
    logic [0:0]  AW_Target_Slave;
    logic [7:0]  AW_Granted_Len;
    logic        Queue_Is_Full;
    logic [31:0] S00_AXI_wdata;
    logic [3:0]  S00_AXI_wstrb;
    logic        S00_AXI_wlast;
    logic        S00_AXI_wvalid;
    logic        S00_AXI_wready;
    logic [31:0] S01_AXI_wdata;
    logic [3:0]  S01_AXI_wstrb;
    logic        S01_AXI_wlast;
    logic        S01_AXI_wvalid;
    logic        S01_AXI_wready;
    logic [31:0] M00_AXI_wdata;
    logic [3:0]  M00_AXI_wstrb;
    logic        M00_AXI_wlast;
    logic        M00_AXI_wvalid;
    logic        M00_AXI_wready;
    logic [31:0] M01_AXI_wdata;
    logic [3:0]  M01_AXI_wstrb;
    logic        M01_AXI_wlast;
    logic        M01_AXI_wvalid;
    logic        M01_AXI_wready;
    logic        W_Len_Error;
    logic        Queue_Overflow;

    w_channel_route_queue dut (
        .ACLK              (ACLK),
        .ARESET            (ARESET),
        .AW_Access_Grant   (AW_Access_Grant),
        .AW_Granted_Master (AW_Granted_Master),
        .AW_Target_Slave   (AW_Target_Slave),
        .AW_Granted_Len    (AW_Granted_Len),
        .Queue_Is_Full     (Queue_Is_Full),
        .S00_AXI_wdata     (S00_AXI_wdata),
        .S00_AXI_wstrb     (S00_AXI_wstrb),
        .S00_AXI_wlast     (S00_AXI_wlast),
        .S00_AXI_wvalid    (S00_AXI_wvalid),
        .S00_AXI_wready    (S00_AXI_wready),
        .S01_AXI_wdata     (S01_AXI_wdata),
        .S01_AXI_wstrb     (S01_AXI_wstrb),
        .S01_AXI_wlast     (S01_AXI_wlast),
        .S01_AXI_wvalid    (S01_AXI_wvalid),
        .S01_AXI_wready    (S01_AXI_wready),
        .M00_AXI_wdata     (M00_AXI_wdata),
        .M00_AXI_wstrb     (M00_AXI_wstrb),
        .M00_AXI_wlast     (M00_AXI_wlast),
        .M00_AXI_wvalid    (M00_AXI_wvalid),
        .M00_AXI_wready    (M00_AXI_wready),
        .M01_AXI_wdata     (M01_AXI_wdata),
        .M01_AXI_wstrb     (M01_AXI_wstrb),
        .M01_AXI_wlast     (M01_AXI_wlast),
        .M01_AXI_wvalid    (M01_AXI_wvalid),
        .M01_AXI_wready    (M01_AXI_wready),
        .W_Len_Error       (W_Len_Error),
        .Queue_Overflow    (Queue_Overflow)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of outstanding bursts and the beat index within the head.
    typedef struct {
        int m;
        int s;
        int len;
    } ent_t;

    ent_t mq[$];
    int   m_beat = 0;
    bit   m_err  = 1'b0;
    bit   m_ovf  = 1'b0;

    ent_t        h;
    logic [31:0] sd [2];
    logic [3:0]  ss [2];
    logic        sv [2];
    logic        sl [2];
    logic        mr [2];
    logic [31:0] ed [2];
    logic [3:0]  es [2];
    logic        ev [2];
    logic        el [2];
    logic        er [2];
    bit          was_full;
    bit          do_pop;

    always @(negedge ACLK) begin
        sd[0] = S00_AXI_wdata;  ss[0] = S00_AXI_wstrb;  sv[0] = S00_AXI_wvalid;
        sl[0] = S00_AXI_wlast;  mr[0] = M00_AXI_wready;
        sd[1] = S01_AXI_wdata;  ss[1] = S01_AXI_wstrb;  sv[1] = S01_AXI_wvalid;
        sl[1] = S01_AXI_wlast;  mr[1] = M01_AXI_wready;
        for (int i = 0; i < 2; i++) begin
            ed[i] = '0; es[i] = '0; ev[i] = 1'b0; el[i] = 1'b0; er[i] = 1'b0;
        end
        if (!ARESET && mq.size() > 0) begin
            h = mq[0];
            ev[h.s] = sv[h.m];
            ed[h.s] = sd[h.m];
            es[h.s] = ss[h.m];
            el[h.s] = (m_beat == h.len);
            er[h.m] = mr[h.s];
        end
        chk("queue_full", Queue_Is_Full, !ARESET && mq.size() == 4);
        chk("len_error", W_Len_Error, !ARESET && m_err);
        chk("overflow", Queue_Overflow, !ARESET && m_ovf);
        chk("s00_wready", S00_AXI_wready, er[0]);
        chk("s01_wready", S01_AXI_wready, er[1]);
        chk("m00_wvalid", M00_AXI_wvalid, ev[0]);
        chk("m01_wvalid", M01_AXI_wvalid, ev[1]);
        chk("m00_wlast", M00_AXI_wlast, el[0]);
        chk("m01_wlast", M01_AXI_wlast, el[1]);
        chk("m00_wdata", M00_AXI_wdata, ed[0]);
        chk("m01_wdata", M01_AXI_wdata, ed[1]);
        chk("m00_wstrb", M00_AXI_wstrb, es[0]);
        chk("m01_wstrb", M01_AXI_wstrb, es[1]);

        // Advance the model to the state the DUT holds after the coming rising edge.
        if (ARESET) begin
            mq.delete();
            m_beat = 0;
            m_err  = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            was_full = (mq.size() == 4);
            do_pop   = 1'b0;
            if (mq.size() > 0) begin
                h = mq[0];
                if (sv[h.m] && mr[h.s]) begin
                    if (sl[h.m] != (m_beat == h.len)) m_err = 1'b1;
                    if (m_beat == h.len) begin
                        do_pop = 1'b1;
                        m_beat = 0;
                    end else begin
                        m_beat++;
                    end
                end
            end
            if (do_pop) void'(mq.pop_front());
            if (AW_Access_Grant) begin
                if (was_full) m_ovf = 1'b1;
                else mq.push_back('{m: int'(AW_Granted_Master), s: int'(AW_Target_Slave),
                                    len: int'(AW_Granted_Len)});
            end
        end
    end

    task automatic idle();
        AW_Access_Grant = 1'b0; AW_Granted_Master = '0; AW_Target_Slave = '0; AW_Granted_Len = '0;
        S00_AXI_wdata = '0; S00_AXI_wstrb = '0; S00_AXI_wlast = 1'b0; S00_AXI_wvalid = 1'b0;
        S01_AXI_wdata = '0; S01_AXI_wstrb = '0; S01_AXI_wlast = 1'b0; S01_AXI_wvalid = 1'b0;
        M00_AXI_wready = 1'b0; M01_AXI_wready = 1'b0;
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic grant(input int m, input int s, input int len);
        AW_Access_Grant   = 1'b1;
        AW_Granted_Master = 1'(m);
        AW_Target_Slave   = 1'(s);
        AW_Granted_Len    = 8'(len);
    endtask

    int sent;
    int cyc;

    initial begin
        ARESET = 1'b1;
        idle();
        S00_AXI_wvalid = 1'b1;
        M00_AXI_wready = 1'b1;
        tick();
        #1;
        chk("rst_m00_wvalid", M00_AXI_wvalid, 0);
        chk("rst_s00_wready", S00_AXI_wready, 0);
        chk("rst_full", Queue_Is_Full, 0);
        tick();
        ARESET = 1'b0;
        idle();

        // Single 4-beat burst M0 -> S0.
        tick(); grant(0, 0, 3);
        tick(); AW_Access_Grant = 1'b0;
        S00_AXI_wvalid = 1'b1; S00_AXI_wstrb = 4'hF; M00_AXI_wready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            S00_AXI_wdata = 32'hA0 + b;
            S00_AXI_wlast = (b == 3);
            #1;
            chk("t1_m00_wvalid", M00_AXI_wvalid, 1);
            chk("t1_m00_wdata", M00_AXI_wdata, 32'hA0 + b);
            chk("t1_m00_wlast", M00_AXI_wlast, b == 3);
            chk("t1_s00_wready", S00_AXI_wready, 1);
            tick();
        end
        #1;
        chk("t1_empty_wvalid", M00_AXI_wvalid, 0);
        chk("t1_empty_wready", S00_AXI_wready, 0);
        chk("t1_len_error", W_Len_Error, 0);
        idle();

        // Back-to-back bursts from different masters to different slaves.
        tick(); grant(0, 1, 0);
        tick(); grant(1, 0, 1);
        tick(); AW_Access_Grant = 1'b0;
        S00_AXI_wvalid = 1'b1; S00_AXI_wdata = 32'h11; S00_AXI_wlast = 1'b1;
        S01_AXI_wvalid = 1'b1; S01_AXI_wdata = 32'h22; S01_AXI_wlast = 1'b0;
        M00_AXI_wready = 1'b1; M01_AXI_wready = 1'b1;
        #1;
        chk("t2_m01_wvalid", M01_AXI_wvalid, 1);
        chk("t2_m01_wdata", M01_AXI_wdata, 32'h11);
        chk("t2_m01_wlast", M01_AXI_wlast, 1);
        chk("t2_m00_idle", M00_AXI_wvalid, 0);
        chk("t2_s01_wready", S01_AXI_wready, 0);
        tick(); #1;
        chk("t2_b2_m00_wvalid", M00_AXI_wvalid, 1);
        chk("t2_b2_m00_wdata", M00_AXI_wdata, 32'h22);
        chk("t2_b2_m00_wlast", M00_AXI_wlast, 0);
        chk("t2_b2_s00_wready", S00_AXI_wready, 0);
        tick(); S01_AXI_wdata = 32'h33; S01_AXI_wlast = 1'b1; #1;
        chk("t2_b3_m00_wlast", M00_AXI_wlast, 1);
        chk("t2_b3_m00_wdata", M00_AXI_wdata, 32'h33);
        tick(); #1;
        chk("t2_done_m00", M00_AXI_wvalid, 0);
        chk("t2_done_m01", M01_AXI_wvalid, 0);
        idle();

        // Fill, overflow, then drain.
        for (int i = 0; i < 4; i++) begin
            tick(); grant(0, 0, 0);
        end
        tick(); AW_Access_Grant = 1'b0; #1;
        chk("t3_full", Queue_Is_Full, 1);
        chk("t3_no_ovf", Queue_Overflow, 0);
        tick(); grant(1, 1, 5);
        tick(); AW_Access_Grant = 1'b0; #1;
        chk("t3_ovf", Queue_Overflow, 1);
        chk("t3_still_full", Queue_Is_Full, 1);
        tick(); S00_AXI_wvalid = 1'b1; S00_AXI_wlast = 1'b1; M00_AXI_wready = 1'b1;
        tick(); S00_AXI_wvalid = 1'b0; M00_AXI_wready = 1'b0; #1;
        chk("t3_not_full", Queue_Is_Full, 0);
        tick(); S00_AXI_wvalid = 1'b1; M00_AXI_wready = 1'b1;
        repeat (3) tick();
        #1;
        chk("t3_drained", M00_AXI_wvalid, 0);
        idle();

        // Push and pop in the same cycle with two entries queued.
        tick(); grant(0, 0, 0);
        tick(); grant(1, 1, 1);
        tick(); grant(0, 0, 0);
        S00_AXI_wvalid = 1'b1; S00_AXI_wlast = 1'b1; S00_AXI_wdata = 32'h44;
        M00_AXI_wready = 1'b1; #1;
        chk("t4_pop_m00", M00_AXI_wvalid, 1);
        tick(); AW_Access_Grant = 1'b0;
        S01_AXI_wvalid = 1'b1; S01_AXI_wdata = 32'h55; M01_AXI_wready = 1'b1; #1;
        chk("t4_order_m01", M01_AXI_wvalid, 1);
        chk("t4_order_m00", M00_AXI_wvalid, 0);
        chk("t4_order_s00r", S00_AXI_wready, 0);
        tick(); S01_AXI_wlast = 1'b1; #1;
        chk("t4_m01_wlast", M01_AXI_wlast, 1);
        tick(); S01_AXI_wvalid = 1'b0; #1;
        chk("t4_third_m00", M00_AXI_wvalid, 1);
        chk("t4_third_wlast", M00_AXI_wlast, 1);
        tick(); idle();

        // Early master wlast is flagged; routing still follows awlen.
        tick(); grant(1, 0, 2);
        tick(); AW_Access_Grant = 1'b0;
        S01_AXI_wvalid = 1'b1; S01_AXI_wdata = 32'h60; M00_AXI_wready = 1'b1; #1;
        chk("t5_err_before", W_Len_Error, 0);
        tick(); S01_AXI_wdata = 32'h61; S01_AXI_wlast = 1'b1; #1;
        chk("t5_b2_wlast", M00_AXI_wlast, 0);
        tick(); S01_AXI_wdata = 32'h62; #1;
        chk("t5_err_set", W_Len_Error, 1);
        chk("t5_b3_wlast", M00_AXI_wlast, 1);
        chk("t5_b3_wvalid", M00_AXI_wvalid, 1);
        tick(); #1;
        chk("t5_popped", M00_AXI_wvalid, 0);
        idle();

        // Backpressure: ready high every third cycle, bounded loop.
        tick(); grant(0, 0, 3);
        tick(); AW_Access_Grant = 1'b0;
        sent = 0;
        cyc  = 0;
        S00_AXI_wvalid = 1'b1;
        while (sent < 4 && cyc < 20) begin
            S00_AXI_wdata  = 32'hB0 + sent;
            S00_AXI_wlast  = (sent == 3);
            M00_AXI_wready = (cyc % 3 == 0);
            #1;
            if (M00_AXI_wvalid && M00_AXI_wready) begin
                chk("t6_data", M00_AXI_wdata, 32'hB0 + sent);
                sent++;
            end
            cyc++;
            tick();
        end
        chk("t6_handshakes", sent, 4);
        #1;
        chk("t6_empty", M00_AXI_wvalid, 0);
        idle();

        // Reset in the middle of a burst.
        tick(); grant(0, 1, 7);
        tick(); AW_Access_Grant = 1'b0; S00_AXI_wvalid = 1'b1; M01_AXI_wready = 1'b1;
        tick();
        tick(); ARESET = 1'b1; #1;
        chk("t7_rst_wvalid", M01_AXI_wvalid, 0);
        chk("t7_rst_wready", S00_AXI_wready, 0);
        chk("t7_rst_wdata", M01_AXI_wdata, 0);
        tick();
        tick(); ARESET = 1'b0; #1;
        chk("t7_after_rst", M01_AXI_wvalid, 0);
        idle();

        // Random traffic; masters mostly send a correct wlast based on the model's head.
        for (int c = 0; c < 4000; c++) begin
            tick();
            ARESET            = ($urandom_range(0, 299) == 0);
            AW_Access_Grant   = ($urandom_range(0, 3) == 0);
            AW_Granted_Master = 1'($urandom_range(0, 1));
            AW_Target_Slave   = 1'($urandom_range(0, 1));
            AW_Granted_Len    = ($urandom_range(0, 63) == 0) ? 8'($urandom_range(0, 255))
                                                             : 8'($urandom_range(0, 3));
            S00_AXI_wvalid = ($urandom_range(0, 3) != 0);
            S00_AXI_wdata  = $urandom;
            S00_AXI_wstrb  = 4'($urandom);
            S01_AXI_wvalid = ($urandom_range(0, 3) != 0);
            S01_AXI_wdata  = $urandom;
            S01_AXI_wstrb  = 4'($urandom);
            if (mq.size() > 0 && mq[0].m == 0) S00_AXI_wlast = (m_beat == mq[0].len);
            else S00_AXI_wlast = 1'($urandom_range(0, 1));
            if (mq.size() > 0 && mq[0].m == 1) S01_AXI_wlast = (m_beat == mq[0].len);
            else S01_AXI_wlast = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 199) == 0) S00_AXI_wlast = ~S00_AXI_wlast;
            if ($urandom_range(0, 199) == 0) S01_AXI_wlast = ~S01_AXI_wlast;
            M00_AXI_wready = ($urandom_range(0, 3) != 0);
            M01_AXI_wready = ($urandom_range(0, 3) != 0);
        end
        tick();
        ARESET = 1'b0;
        idle();
        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
